// File: rtl/pc_redirect_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_redirect_ctrl_pkg
//  Brief    : Shared types for the fetch PC redirect sequencer. Contains the
//             redirect source codes, the FSM state codes and the address width.
//  Revision : 1.0  initial release
// ============================================================================
package pc_redirect_ctrl_pkg;

  // Instruction address bus width used across the fetch front end
  localparam int c_INST_ADDR_W = 32;

  // Redirect source codes. The numeric order is also the priority order.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BTB  = 2'd1,
    SRC_PRE  = 2'd2,
    SRC_ROB  = 2'd3
  } redir_src_e;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_RECOVER = 2'd1,
    ST_FLUSH   = 2'd2
  } ctrl_state_e;

  // PRE and ROB redirects invalidate everything already in flight
  function automatic logic src_bumps_epoch(input redir_src_e src);
    return (src == SRC_PRE) || (src == SRC_ROB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_redirect_ctrl_redir_pick.sv
`default_nettype none
// ============================================================================
//  Module   : pc_redirect_ctrl_redir_pick
//  Brief    : Combinational priority select between the held (pending)
//             redirect and the three live sources. ROB > PRE > BTB; at equal
//             source the live request wins over the held one.
//  Revision : 1.0  initial release
// ============================================================================
module pc_redirect_ctrl_redir_pick
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int ADDR_W = c_INST_ADDR_W
) (
  input  logic              pend_valid_i,
  input  redir_src_e        pend_src_i,
  input  logic [ADDR_W-1:0] pend_pc_i,
  input  logic              rob_valid_i,
  input  logic [ADDR_W-1:0] rob_pc_i,
  input  logic              pre_valid_i,
  input  logic [ADDR_W-1:0] pre_pc_i,
  input  logic              btb_valid_i,
  input  logic [ADDR_W-1:0] btb_pc_i,
  output logic              valid_o,
  output redir_src_e        src_o,
  output logic [ADDR_W-1:0] pc_o
);

  logic w_pend_rob;
  logic w_pend_pre;
  logic w_pend_btb;

  assign w_pend_rob = pend_valid_i && (pend_src_i == SRC_ROB);
  assign w_pend_pre = pend_valid_i && (pend_src_i == SRC_PRE);
  assign w_pend_btb = pend_valid_i && (pend_src_i == SRC_BTB);

  // Walk sources from highest to lowest; live beats held at the same level
  always_comb begin
    valid_o = 1'b0;
    src_o   = SRC_NONE;
    pc_o    = '0;
    if (rob_valid_i) begin
      valid_o = 1'b1;
      src_o   = SRC_ROB;
      pc_o    = rob_pc_i;
    end else if (w_pend_rob) begin
      valid_o = 1'b1;
      src_o   = SRC_ROB;
      pc_o    = pend_pc_i;
    end else if (pre_valid_i) begin
      valid_o = 1'b1;
      src_o   = SRC_PRE;
      pc_o    = pre_pc_i;
    end else if (w_pend_pre) begin
      valid_o = 1'b1;
      src_o   = SRC_PRE;
      pc_o    = pend_pc_i;
    end else if (btb_valid_i) begin
      valid_o = 1'b1;
      src_o   = SRC_BTB;
      pc_o    = btb_pc_i;
    end else if (w_pend_btb) begin
      valid_o = 1'b1;
      src_o   = SRC_BTB;
      pc_o    = pend_pc_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pc_redirect_ctrl
//  Brief    : Fetch PC sequencer. Merges BTB / predecode / ROB redirects into
//             one redirect, drives PC stop/flush, holds a redirect across
//             stalls and maintains the fetch epoch used to squash stale
//             fetches.
//  Revision : 1.0  initial release
// ============================================================================
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int ADDR_W      = c_INST_ADDR_W,
  parameter int EPOCH_W     = 3,
  parameter int FLUSH_CYC   = 2,
  parameter int RECOVER_CYC = 2
) (
  input  logic               Clk,
  input  logic               Rest,
  input  logic               CtrlFlush,
  input  logic               BackendStall,
  input  logic               ICacheReady,
  input  logic               BtbAble,
  input  logic [ADDR_W-1:0]  BtbPc,
  input  logic               PreAble,
  input  logic [ADDR_W-1:0]  PrePc,
  input  logic               RobAble,
  input  logic [ADDR_W-1:0]  RobPc,
  output logic               PcStop,
  output logic               PcFlash,
  output logic               RedirAble,
  output logic [ADDR_W-1:0]  RedirPc,
  output logic [1:0]         RedirSrc,
  output logic               KillFetch,
  output logic [EPOCH_W-1:0] FetchEpoch
);

  // One shared down-counter serves both FLUSH and RECOVER
  localparam int CNT_MAX = (FLUSH_CYC > RECOVER_CYC) ? FLUSH_CYC : RECOVER_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] c_FLUSH_LOAD   = CNT_W'(FLUSH_CYC);
  localparam logic [CNT_W-1:0] c_RECOVER_LOAD = CNT_W'(RECOVER_CYC);
  localparam logic [CNT_W-1:0] c_CNT_ONE      = CNT_W'(1);
  localparam bit               c_HAS_RECOVER  = (RECOVER_CYC > 0);

  ctrl_state_e         state_q,      state_d;
  logic [CNT_W-1:0]    cnt_q,        cnt_d;
  logic [EPOCH_W-1:0]  epoch_q,      epoch_d;
  logic                pend_valid_q, pend_valid_d;
  redir_src_e          pend_src_q,   pend_src_d;
  logic [ADDR_W-1:0]   pend_pc_q,    pend_pc_d;

  logic                w_stall;
  logic                w_in_run;
  logic                w_in_flush;
  logic                w_pick_valid;
  redir_src_e          w_pick_src;
  logic [ADDR_W-1:0]   w_pick_pc;
  logic                w_redir_able;
  redir_src_e          w_redir_src;
  logic [ADDR_W-1:0]   w_redir_pc;
  logic                w_kill;

  assign w_stall    = BackendStall | ~ICacheReady;
  assign w_in_run   = (state_q == ST_RUN);
  assign w_in_flush = (state_q == ST_FLUSH);

  // BTB/PRE are only trusted in RUN; ROB is honoured everywhere except FLUSH
  pc_redirect_ctrl_redir_pick #(
    .ADDR_W (ADDR_W)
  ) u_pick (
    .pend_valid_i (pend_valid_q),
    .pend_src_i   (pend_src_q),
    .pend_pc_i    (pend_pc_q),
    .rob_valid_i  (RobAble & ~w_in_flush),
    .rob_pc_i     (RobPc),
    .pre_valid_i  (PreAble & w_in_run),
    .pre_pc_i     (PrePc),
    .btb_valid_i  (BtbAble & w_in_run),
    .btb_pc_i     (BtbPc),
    .valid_o      (w_pick_valid),
    .src_o        (w_pick_src),
    .pc_o         (w_pick_pc)
  );

  // Next-state, pending update and same-cycle redirect issue
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    epoch_d      = epoch_q;
    pend_valid_d = pend_valid_q;
    pend_src_d   = pend_src_q;
    pend_pc_d    = pend_pc_q;
    w_redir_able = 1'b0;
    w_redir_src  = SRC_NONE;
    w_redir_pc   = '0;
    w_kill       = 1'b0;

    if (CtrlFlush) begin
      // Flush overrides every redirect source and any held request
      state_d      = ST_FLUSH;
      cnt_d        = c_FLUSH_LOAD;
      pend_valid_d = 1'b0;
      epoch_d      = epoch_q + EPOCH_W'(1);
      w_kill       = 1'b1;
    end else if (w_in_flush) begin
      if (cnt_q <= c_CNT_ONE) begin
        state_d = c_HAS_RECOVER ? ST_RECOVER : ST_RUN;
        cnt_d   = c_RECOVER_LOAD;
      end else begin
        cnt_d = cnt_q - c_CNT_ONE;
      end
    end else begin
      // RECOVER times out regardless of stall; a ROB issue below may reload it
      if (state_q == ST_RECOVER) begin
        if (cnt_q <= c_CNT_ONE) begin
          state_d = ST_RUN;
        end
        cnt_d = (cnt_q == '0) ? '0 : (cnt_q - c_CNT_ONE);
      end

      if (w_stall) begin
        // Picker already ranks against the held entry, so lower never overwrites higher
        if (w_pick_valid) begin
          pend_valid_d = 1'b1;
          pend_src_d   = w_pick_src;
          pend_pc_d    = w_pick_pc;
        end
      end else begin
        pend_valid_d = 1'b0;
        if (w_pick_valid) begin
          w_redir_able = 1'b1;
          w_redir_src  = w_pick_src;
          w_redir_pc   = w_pick_pc;
          if (src_bumps_epoch(w_pick_src)) begin
            epoch_d = epoch_q + EPOCH_W'(1);
            w_kill  = 1'b1;
          end
          if ((w_pick_src == SRC_ROB) && c_HAS_RECOVER) begin
            state_d = ST_RECOVER;
            cnt_d   = c_RECOVER_LOAD;
          end
        end
      end
    end
  end

  // State register; reset discards any held redirect
  always_ff @(posedge Clk) begin
    if (Rest) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      epoch_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_src_q   <= SRC_NONE;
      pend_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      epoch_q      <= epoch_d;
      pend_valid_q <= pend_valid_d;
      pend_src_q   <= pend_src_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  // Outputs are held quiet while reset is asserted
  assign PcStop     = ~Rest & w_stall & ~w_in_flush;
  assign PcFlash    = ~Rest & w_in_flush;
  assign RedirAble  = ~Rest & w_redir_able;
  assign RedirPc    = Rest ? '0 : w_redir_pc;
  assign RedirSrc   = Rest ? SRC_NONE : w_redir_src;
  assign KillFetch  = ~Rest & w_kill;
  assign FetchEpoch = Rest ? '0 : epoch_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_redirect_ctrl
//  Brief    : Self-checking bench for pc_redirect_ctrl: directed vector table,
//             hand-written epoch-wrap and reset sequences, then random stimulus
//             against a behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_redirect_ctrl;

  localparam int ADDR_W      = 32;
  localparam int EPOCH_W     = 3;
  localparam int FLUSH_CYC   = 2;
  localparam int RECOVER_CYC = 2;
  localparam int N_RANDOM    = 3000;

  logic               Clk = 1'b0;
  logic               Rest, CtrlFlush, BackendStall, ICacheReady;
  logic               BtbAble, PreAble, RobAble;
  logic [ADDR_W-1:0]  BtbPc, PrePc, RobPc;
  logic               PcStop, PcFlash, RedirAble, KillFetch;
  logic [ADDR_W-1:0]  RedirPc;
  logic [1:0]         RedirSrc;
  logic [EPOCH_W-1:0] FetchEpoch;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  pc_redirect_ctrl #(
    .ADDR_W      (ADDR_W),
    .EPOCH_W     (EPOCH_W),
    .FLUSH_CYC   (FLUSH_CYC),
    .RECOVER_CYC (RECOVER_CYC)
  ) dut (
    .Clk          (Clk),
    .Rest         (Rest),
    .CtrlFlush    (CtrlFlush),
    .BackendStall (BackendStall),
    .ICacheReady  (ICacheReady),
    .BtbAble      (BtbAble),
    .BtbPc        (BtbPc),
    .PreAble      (PreAble),
    .PrePc        (PrePc),
    .RobAble      (RobAble),
    .RobPc        (RobPc),
    .PcStop       (PcStop),
    .PcFlash      (PcFlash),
    .RedirAble    (RedirAble),
    .RedirPc      (RedirPc),
    .RedirSrc     (RedirSrc),
    .KillFetch    (KillFetch),
    .FetchEpoch   (FetchEpoch)
  );

  typedef struct {
    logic        rst, flush, bs, icr;
    logic        btb; logic [31:0] btbpc;
    logic        pre; logic [31:0] prepc;
    logic        rob; logic [31:0] robpc;
    logic        e_able; logic [1:0] e_src; logic [31:0] e_pc;
    logic        e_kill; logic [2:0] e_epoch; logic e_stop; logic e_flash;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rst, flush, bs, icr,
    input logic btb, input logic [31:0] btbpc,
    input logic pre, input logic [31:0] prepc,
    input logic rob, input logic [31:0] robpc,
    input logic e_able, input logic [1:0] e_src, input logic [31:0] e_pc,
    input logic e_kill, input logic [2:0] e_epoch, input logic e_stop, input logic e_flash);
    vec_t v;
    v.rst = rst; v.flush = flush; v.bs = bs; v.icr = icr;
    v.btb = btb; v.btbpc = btbpc; v.pre = pre; v.prepc = prepc;
    v.rob = rob; v.robpc = robpc;
    v.e_able = e_able; v.e_src = e_src; v.e_pc = e_pc;
    v.e_kill = e_kill; v.e_epoch = e_epoch; v.e_stop = e_stop; v.e_flash = e_flash;
    return v;
  endfunction

  task automatic drive(input logic rst, flush, bs, icr, btb, input logic [31:0] btbpc,
                       input logic pre, input logic [31:0] prepc,
                       input logic rob, input logic [31:0] robpc);
    Rest = rst; CtrlFlush = flush; BackendStall = bs; ICacheReady = icr;
    BtbAble = btb; BtbPc = btbpc; PreAble = pre; PrePc = prepc;
    RobAble = rob; RobPc = robpc;
  endtask

  // The target PC is only meaningful while a redirect is expected
  task automatic check(input string name, input logic e_able, input logic [1:0] e_src,
                       input logic [31:0] e_pc, input logic e_kill, input logic [2:0] e_epoch,
                       input logic e_stop, input logic e_flash);
    logic [40:0] act, expv;
    act  = {RedirAble, RedirSrc, (e_able ? RedirPc : 32'h0), KillFetch, FetchEpoch, PcStop, PcFlash};
    expv = {e_able, e_src, (e_able ? e_pc : 32'h0), e_kill, e_epoch, e_stop, e_flash};
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got able=%0b src=%0d pc=%h kill=%0b epoch=%0d stop=%0b flash=%0b ; expected able=%0b src=%0d pc=%h kill=%0b epoch=%0d stop=%0b flash=%0b",
               name, RedirAble, RedirSrc, RedirPc, KillFetch, FetchEpoch, PcStop, PcFlash,
               e_able, e_src, e_pc, e_kill, e_epoch, e_stop, e_flash);
    end
  endtask

  // Called just after a rising edge: drive, sample at the falling edge, advance
  task automatic apply(input vec_t v, input string name);
    drive(v.rst, v.flush, v.bs, v.icr, v.btb, v.btbpc, v.pre, v.prepc, v.rob, v.robpc);
    @(negedge Clk);
    check(name, v.e_able, v.e_src, v.e_pc, v.e_kill, v.e_epoch, v.e_stop, v.e_flash);
    @(posedge Clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  int          m_flush_left, m_mask_left, m_pend_rank, m_epoch;
  logic [31:0] m_pend_pc;

  // Produces this cycle's expected outputs and advances the model by one edge
  task automatic model_cycle(input logic rst, flush, bs, icr, btb, input logic [31:0] btbpc,
                             input logic pre, input logic [31:0] prepc,
                             input logic rob, input logic [31:0] robpc,
                             output logic e_able, output logic [1:0] e_src, output logic [31:0] e_pc,
                             output logic e_kill, output logic [2:0] e_epoch,
                             output logic e_stop, output logic e_flash);
    bit          stall, in_flush, in_rec;
    bit          live_v [4];
    logic [31:0] live_pc[4];
    int          best;
    logic [31:0] best_pc;
    e_able = 0; e_src = 0; e_pc = 0; e_kill = 0; e_epoch = 0; e_stop = 0; e_flash = 0;
    if (rst) begin
      m_flush_left = 0; m_mask_left = 0; m_pend_rank = 0; m_pend_pc = 0; m_epoch = 0;
      return;
    end
    stall    = bs || !icr;
    in_flush = m_flush_left > 0;
    in_rec   = !in_flush && m_mask_left > 0;
    e_epoch  = 3'(m_epoch);
    e_stop   = stall && !in_flush;
    e_flash  = in_flush;
    live_v[0] = 0;                              live_pc[0] = 0;
    live_v[1] = btb && !in_flush && !in_rec;    live_pc[1] = btbpc;
    live_v[2] = pre && !in_flush && !in_rec;    live_pc[2] = prepc;
    live_v[3] = rob && !in_flush;               live_pc[3] = robpc;
    best = 0; best_pc = 0;
    for (int r = 3; r >= 1; r--) begin
      if (best == 0) begin
        if (live_v[r]) begin best = r; best_pc = live_pc[r]; end
        else if (m_pend_rank == r) begin best = r; best_pc = m_pend_pc; end
      end
    end
    if (flush) begin
      e_kill = 1;
      m_flush_left = FLUSH_CYC; m_mask_left = 0; m_pend_rank = 0;
      m_epoch = (m_epoch + 1) % (1 << EPOCH_W);
    end else if (in_flush) begin
      m_flush_left--;
      if (m_flush_left == 0) m_mask_left = RECOVER_CYC;
    end else begin
      if (in_rec) m_mask_left--;
      if (stall) begin
        if (best != 0) begin m_pend_rank = best; m_pend_pc = best_pc; end
      end else begin
        m_pend_rank = 0;
        if (best != 0) begin
          e_able = 1; e_src = 2'(best); e_pc = best_pc;
          if (best >= 2) begin
            e_kill = 1;
            m_epoch = (m_epoch + 1) % (1 << EPOCH_W);
          end
          if (best == 3) m_mask_left = RECOVER_CYC;
        end
      end
    end
  endtask

  initial begin
    logic        r_rst, r_fl, r_bs, r_icr, r_btb, r_pre, r_rob;
    logic [31:0] r_bpc, r_ppc, r_rpc;
    logic        x_able, x_kill, x_stop, x_flash;
    logic [1:0]  x_src;
    logic [31:0] x_pc;
    logic [2:0]  x_epoch;

    // ---- directed vector table (one row per cycle) ----
    //               rst fl bs icr btb pc           pre pc          rob pc          able src pc           kill ep stop flash
    vecs.push_back(mk(1, 0, 0, 1, 0, 0,           0, 0,           0, 0,           0, 0, 0,            0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,           0, 0,           0, 0,           0, 0, 0,            0, 0, 0, 0));
    // BTB redirect, no stall
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h1C000040, 0, 0,          0, 0,           1, 1, 32'h1C000040, 0, 0, 0, 0));
    // held redirects during a stall: PRE survives a later BTB
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h100,     0, 0,           0, 0,           0, 0, 0,            0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0,           1, 32'h200,     0, 0,           0, 0, 0,            0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h300,     0, 0,           0, 0,           0, 0, 0,            0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0,           0, 0,           0, 0,           0, 0, 0,            0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,           0, 0,           0, 0,           1, 2, 32'h200,      1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,           0, 0,           0, 0,           0, 0, 0,            0, 1, 0, 0));
    // ROB wins over PRE+BTB, then two masked cycles
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h600,     1, 32'h500,     1, 32'h80,      1, 3, 32'h80,       1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h604,     1, 32'h504,     0, 0,           0, 0, 0,            0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h608,     1, 32'h508,     0, 0,           0, 0, 0,            0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h700,     0, 0,           0, 0,           1, 1, 32'h700,      0, 2, 0, 0));
    // flush while a ROB redirect is held
    vecs.push_back(mk(0, 0, 1, 1, 0, 0,           0, 0,           1, 32'h900,     0, 0, 0,            0, 2, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0,           0, 0,           0, 0,           0, 0, 0,            1, 2, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 32'h111,     0, 0,           1, 32'h222,     0, 0, 0,            0, 3, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,           0, 0,           1, 32'h333,     0, 0, 0,            0, 3, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h444,     0, 0,           0, 0,           0, 0, 0,            0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h448,     0, 0,           0, 0,           0, 0, 0,            0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h44C,     0, 0,           0, 0,           1, 1, 32'h44C,      0, 3, 0, 0));
    // ROB inside RECOVER reloads the mask window
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,           0, 0,           1, 32'hA00,     1, 3, 32'hA00,      1, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,           1, 32'hB00,     0, 0,           0, 0, 0,            0, 4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,           0, 0,           1, 32'hA10,     1, 3, 32'hA10,      1, 4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,           1, 32'hB04,     0, 0,           0, 0, 0,            0, 5, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,           1, 32'hB08,     0, 0,           0, 0, 0,            0, 5, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,           1, 32'hB0C,     0, 0,           1, 2, 32'hB0C,      1, 5, 0, 0));
    // equal source: live replaces held
    vecs.push_back(mk(0, 0, 1, 1, 0, 0,           1, 32'hC00,     0, 0,           0, 0, 0,            0, 6, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,           1, 32'hC04,     0, 0,           1, 2, 32'hC04,      1, 6, 0, 0));
    // held ROB beats live BTB; epoch wraps 7 -> 0
    vecs.push_back(mk(0, 0, 1, 1, 0, 0,           0, 0,           1, 32'hD00,     0, 0, 0,            0, 7, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'hE00,     0, 0,           0, 0,           1, 3, 32'hD00,      1, 7, 0, 0));
    // icache-not-ready stall still lets RECOVER count down
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0,           0, 0,           0, 0, 0,            0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'hE04,     0, 0,           0, 0,           0, 0, 0,            0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'hF00,     0, 0,           0, 0,           1, 1, 32'hF00,      0, 0, 0, 0));

    drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    @(posedge Clk);
    #1;
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // ---- eight back-to-back PRE redirects walk the epoch through a full wrap ----
    for (int i = 0; i < 8; i++)
      apply(mk(0, 0, 0, 1, 0, 0, 1, 32'h1000 + 32'(4 * i), 0, 0, 1, 2, 32'h1000 + 32'(4 * i), 1, 3'(i), 0, 0),
            $sformatf("epoch_walk%0d", i));
    apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "epoch_wrapped");

    // ---- reset in the middle of FLUSH, and reset with a held redirect ----
    apply(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 32'h55, 0, 0, 0, 0, 0, 1, 0), "rst_seq_hold");
    apply(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0,      0, 0, 0, 1, 0, 1, 0), "rst_seq_flush");
    apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 1, 0, 1), "rst_seq_inflush");
    drive(1, 0, 1, 1, 1, 32'h66, 0, 0, 1, 32'h67);
    @(posedge Clk);
    #1;
    apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0), "rst_after_flush");
    apply(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 32'h77, 0, 0, 0, 0, 0, 1, 0), "rst_seq_hold2");
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    @(posedge Clk);
    #1;
    apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0), "rst_pend_dropped");
    apply(mk(0, 0, 0, 1, 1, 32'h88, 0, 0, 0, 0, 1, 1, 32'h88, 0, 0, 0, 0), "rst_back_to_run");

    // ---- random stimulus against the reference model ----
    for (int c = 0; c < N_RANDOM; c++) begin
      r_rst = (c == 0) || ($urandom_range(99) < 1);
      r_fl  = $urandom_range(99) < 3;
      r_bs  = $urandom_range(99) < 30;
      r_icr = $urandom_range(99) < 85;
      r_btb = $urandom_range(99) < 30;
      r_pre = $urandom_range(99) < 20;
      r_rob = $urandom_range(99) < 10;
      r_bpc = $urandom & 32'hFFFF_FFFC;
      r_ppc = $urandom & 32'hFFFF_FFFC;
      r_rpc = $urandom & 32'hFFFF_FFFC;
      drive(r_rst, r_fl, r_bs, r_icr, r_btb, r_bpc, r_pre, r_ppc, r_rob, r_rpc);
      @(negedge Clk);
      model_cycle(r_rst, r_fl, r_bs, r_icr, r_btb, r_bpc, r_pre, r_ppc, r_rob, r_rpc,
                  x_able, x_src, x_pc, x_kill, x_epoch, x_stop, x_flash);
      if (!r_rst)
        check($sformatf("rand%0d", c), x_able, x_src, x_pc, x_kill, x_epoch, x_stop, x_flash);
      @(posedge Clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
